// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_ctrl
// Purpose  : HUB75 LED panel scan controller (1/16 scan, 2 halves, column shift,
//            latch, bit-plane display). Macro SCAN_BCM_EN selects 4-plane BCM;
//            otherwise only the MSB plane is displayed.
// Revision : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl #(
    parameter int COLS    = 32,
    parameter int BASE_ON = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        fb_rd,
    output logic [8:0]  fb_addr,
    input  logic [11:0] fb_rdata_top,
    input  logic [11:0] fb_rdata_bot,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        R0,
    output logic        G0,
    output logic        B0,
    output logic        R1,
    output logic        G1,
    output logic        B1,
    output logic        clk_shft,
    output logic        LAT,
    output logic        OE,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(BASE_ON * 8 + 1);

`ifdef SCAN_BCM_EN
    localparam logic [1:0] FIRST_PLANE = 2'd0;
`else
    localparam logic [1:0] FIRST_PLANE = 2'd3;
`endif
    localparam logic [1:0] LAST_PLANE = 2'd3;
    localparam logic [4:0] LAST_COL   = 5'(COLS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_CLOCK   = 3'd3;
    localparam logic [2:0] S_BLANK   = 3'd4;
    localparam logic [2:0] S_LATCH   = 3'd5;
    localparam logic [2:0] S_DISPLAY = 3'd6;
    localparam logic [2:0] S_NEXT    = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [3:0]       row_q, row_d;
    logic [1:0]       plane_q, plane_d;
    logic [4:0]       col_q, col_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       rgb_q, rgb_d;
    logic [3:0]       addr_q, addr_d;

    logic [5:0]       rgb_fetch;
    logic             plane_wrap;
    logic [1:0]       disp_shift;
    logic [CNT_W-1:0] disp_load;

    // Nibble bit select: R at 8+plane, G at 4+plane, B at plane.
    assign rgb_fetch = {fb_rdata_top[{2'b10, plane_q}], fb_rdata_top[{2'b01, plane_q}],
                        fb_rdata_top[{2'b00, plane_q}], fb_rdata_bot[{2'b10, plane_q}],
                        fb_rdata_bot[{2'b01, plane_q}], fb_rdata_bot[{2'b00, plane_q}]};
    assign plane_wrap = (plane_q == LAST_PLANE);
    // Without BCM the plane sits at 3 but the display length stays BASE_ON.
    assign disp_shift = plane_q - FIRST_PLANE;
    assign disp_load  = CNT_W'((BASE_ON << disp_shift) - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (en) state_d = S_FETCH;
            S_FETCH:   state_d = S_SETUP;
            S_SETUP:   state_d = S_CLOCK;
            S_CLOCK:   state_d = (col_q == LAST_COL) ? S_BLANK : S_FETCH;
            S_BLANK:   state_d = S_LATCH;
            S_LATCH:   state_d = S_DISPLAY;
            S_DISPLAY: if (cnt_q == '0) state_d = S_NEXT;
            S_NEXT:    state_d = en ? S_FETCH : S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fb_rd      = (state_q == S_FETCH);
        fb_addr    = {row_q, col_q};
        clk_shft   = (state_q == S_CLOCK);
        LAT        = (state_q == S_LATCH);
        OE         = (state_q != S_DISPLAY);
        frame_done = (state_q == S_NEXT) && plane_wrap && (row_q == 4'd15);
        // Data is driven straight from the read port in SETUP so it is stable
        // a full cycle before the shift clock rises.
        {R0, G0, B0, R1, G1, B1} = (state_q == S_SETUP) ? rgb_fetch : rgb_q;
        {D, C, B, A} = addr_q;
    end

    always_comb begin
        row_d   = row_q;
        plane_d = plane_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        rgb_d   = rgb_q;
        addr_d  = addr_q;
        case (state_q)
            S_SETUP: rgb_d = rgb_fetch;
            S_CLOCK: begin
                if (col_q == LAST_COL) begin
                    col_d  = '0;
                    addr_d = row_q;
                end else begin
                    col_d = col_q + 5'd1;
                end
            end
            S_LATCH:   cnt_d = disp_load;
            S_DISPLAY: if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            S_NEXT: begin
                plane_d = plane_wrap ? FIRST_PLANE : plane_q + 2'd1;
                if (plane_wrap) row_d = row_q + 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            plane_q <= FIRST_PLANE;
            col_q   <= '0;
            cnt_q   <= '0;
            rgb_q   <= '0;
            addr_q  <= '0;
        end else begin
            row_q   <= row_d;
            plane_q <= plane_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            rgb_q   <= rgb_d;
            addr_q  <= addr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hub75_scan_ctrl
// Purpose  : Directed self-checking bench for hub75_scan_ctrl (both builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_ctrl;

    localparam int COLS    = 32;
    localparam int BASE_ON = 8;
`ifdef SCAN_BCM_EN
    localparam int NPL     = 4;
    localparam int FIRST_P = 0;
`else
    localparam int NPL     = 1;
    localparam int FIRST_P = 3;
`endif
    localparam int LAST_P  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        fb_rd;
    logic [8:0]  fb_addr;
    logic [11:0] rd_top = '0;
    logic [11:0] rd_bot = '0;
    logic        A, B, C, D, R0, G0, B0, R1, G1, B1, clk_shft, LAT, OE, frame_done;

    logic [11:0] mem_top [0:511];
    logic [11:0] mem_bot [0:511];

    int n_checks = 0;
    int n_errors = 0;

    hub75_scan_ctrl #(.COLS(COLS), .BASE_ON(BASE_ON)) dut (
        .clk(clk), .rst(rst), .en(en), .fb_rd(fb_rd), .fb_addr(fb_addr),
        .fb_rdata_top(rd_top), .fb_rdata_bot(rd_bot),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .clk_shft(clk_shft), .LAT(LAT), .OE(OE), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Synchronous framebuffer: data valid the cycle after fb_rd.
    always @(posedge clk) begin
        if (fb_rd) begin
            rd_top <= mem_top[fb_addr];
            rd_bot <= mem_bot[fb_addr];
        end
    end

    function automatic int dlen(input int p);
        return BASE_ON << (p - FIRST_P);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_after);
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) tick();
        en  = en_after;
        rst = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int i = 0; i < 512; i++) begin
            mem_top[i] = (mode == 1) ? 12'hFFF : (mode == 2) ? 12'($urandom) : 12'h000;
            mem_bot[i] = (mode == 1) ? 12'hFFF : (mode == 2) ? 12'($urandom) : 12'h000;
        end
    endtask

    // Follows one row-plane up to and including its NEXT cycle, recording what
    // the panel saw; RGB at each shift-clock rise is compared to the memory.
    task automatic capture(input logic [3:0] row, input int plane, input int drop_col,
                           output int shifts, output int rgb_err, output int ones,
                           output int lats, output int oe_low, output int fd,
                           output logic [3:0] lat_addr, output int rdcnt,
                           output int viol, output bit tout);
        bit          seen_low;
        logic [11:0] t, b;
        logic [5:0]  exp_rgb;
        shifts = 0; rgb_err = 0; ones = 0; lats = 0; oe_low = 0; fd = 0;
        lat_addr = 4'hx; rdcnt = 0; viol = 0; tout = 1'b0; seen_low = 1'b0;
        for (int cyc = 0; ; cyc++) begin
            if (cyc >= 600) begin
                tout = 1'b1;
                break;
            end
            tick();
            if (fb_rd) rdcnt++;
            if (clk_shft) begin
                t = mem_top[{row, 5'(shifts)}];
                b = mem_bot[{row, 5'(shifts)}];
                exp_rgb = {t[8+plane], t[4+plane], t[plane], b[8+plane], b[4+plane], b[plane]};
                if ({R0, G0, B0, R1, G1, B1} !== exp_rgb) rgb_err++;
                if ({R0, G0, B0, R1, G1, B1} != 6'd0) ones++;
                shifts++;
                if (shifts == drop_col) en = 1'b0;
            end
            if (LAT) begin
                lats++;
                lat_addr = {D, C, B, A};
            end
            if (!OE) begin
                oe_low++;
                seen_low = 1'b1;
            end
            if ((clk_shft || LAT || fb_rd) && !OE) viol++;
            if (frame_done) fd++;
            if (seen_low && OE) break;
        end
    endtask

    task automatic test_reset;
        int busy;
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) tick();
        n_checks++; if (OE !== 1'b1) begin n_errors++; $display("FAIL reset_oe: got %b expected 1", OE); end
        n_checks++; if (LAT !== 1'b0) begin n_errors++; $display("FAIL reset_lat: got %b expected 0", LAT); end
        n_checks++; if (clk_shft !== 1'b0) begin n_errors++; $display("FAIL reset_clk_shft: got %b expected 0", clk_shft); end
        n_checks++; if (fb_rd !== 1'b0) begin n_errors++; $display("FAIL reset_fb_rd: got %b expected 0", fb_rd); end
        n_checks++; if (fb_addr !== 9'd0) begin n_errors++; $display("FAIL reset_fb_addr: got %h expected 0", fb_addr); end
        n_checks++; if ({D, C, B, A} !== 4'd0) begin n_errors++; $display("FAIL reset_row_addr: got %h expected 0", {D, C, B, A}); end
        n_checks++; if ({R0, G0, B0, R1, G1, B1} !== 6'd0) begin n_errors++; $display("FAIL reset_rgb: got %b expected 000000", {R0, G0, B0, R1, G1, B1}); end
        n_checks++; if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        en  = 1'b0;
        rst = 1'b0;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (fb_rd || clk_shft || LAT || !OE) busy++;
        end
        n_checks++; if (busy !== 0) begin n_errors++; $display("FAIL idle_hold: got %0d active cycles expected 0", busy); end
    endtask

    task automatic test_all_white;
        int sh, re, on, la, ol, fd, rc, vi;
        logic [3:0] ad;
        bit to;
        fill(1);
        do_reset(1'b1);
        capture(4'd0, FIRST_P, -1, sh, re, on, la, ol, fd, ad, rc, vi, to);
        n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL white_timeout: got %b expected 0", to); end
        n_checks++; if (sh !== 32) begin n_errors++; $display("FAIL white_shifts: got %0d expected 32", sh); end
        n_checks++; if (on !== 32 || re !== 0) begin n_errors++; $display("FAIL white_rgb: got %0d lit, %0d wrong expected 32 lit, 0 wrong", on, re); end
        n_checks++; if (la !== 1) begin n_errors++; $display("FAIL white_lat: got %0d expected 1", la); end
        n_checks++; if (ol !== 8) begin n_errors++; $display("FAIL white_oe_low: got %0d expected 8", ol); end
        n_checks++; if (rc !== 32) begin n_errors++; $display("FAIL white_fb_rd: got %0d expected 32", rc); end
        n_checks++; if (ad !== 4'd0) begin n_errors++; $display("FAIL white_row_addr: got %h expected 0", ad); end
        n_checks++; if (vi !== 0) begin n_errors++; $display("FAIL white_oe_overlap: got %0d expected 0", vi); end
    endtask

    task automatic test_pattern;
        int sh, re, on, la, ol, fd, rc, vi, err_sum;
        logic [3:0] ad, r;
        int p;
        bit to;
        fill(2);
        do_reset(1'b1);
        r = 4'd0; p = FIRST_P; err_sum = 0;
        for (int k = 0; k < NPL + 1; k++) begin
            capture(r, p, -1, sh, re, on, la, ol, fd, ad, rc, vi, to);
            err_sum += re + (to ? 1 : 0) + ((sh != 32) ? 1 : 0);
            if (p == LAST_P) begin p = FIRST_P; r = r + 4'd1; end else p++;
        end
        n_checks++; if (err_sum !== 0) begin n_errors++; $display("FAIL pattern_rgb: got %0d bad shifts expected 0", err_sum); end
    endtask

    task automatic test_full_frame;
        int sh, re, on, la, ol, fd, rc, vi;
        int rgb_bad, shift_bad, lat_bad, oe_bad, addr_bad, fd_bad, fd_total, ones_total, ones_px, tos;
        logic [3:0] ad, r;
        int p;
        bit to;
        fill(0);
        mem_top[{4'd5, 5'd7}] = 12'h800;
        do_reset(1'b1);
        r = 4'd0; p = FIRST_P;
        rgb_bad = 0; shift_bad = 0; lat_bad = 0; oe_bad = 0; addr_bad = 0;
        fd_bad = 0; fd_total = 0; ones_total = 0; ones_px = 0; tos = 0;
        for (int k = 0; k < 16 * NPL; k++) begin
            capture(r, p, -1, sh, re, on, la, ol, fd, ad, rc, vi, to);
            rgb_bad    += re;
            ones_total += on;
            if (r == 4'd5 && p == 3) ones_px += on;
            if (sh != 32) shift_bad++;
            if (la != 1) lat_bad++;
            if (ol != dlen(p)) oe_bad++;
            if (ad !== r) addr_bad++;
            if (fd != ((r == 4'd15 && p == LAST_P) ? 1 : 0)) fd_bad++;
            fd_total += fd;
            tos += to ? 1 : 0;
            if (p == LAST_P) begin p = FIRST_P; r = r + 4'd1; end else p++;
        end
        n_checks++; if (tos !== 0) begin n_errors++; $display("FAIL frame_timeout: got %0d expected 0", tos); end
        n_checks++; if (rgb_bad !== 0) begin n_errors++; $display("FAIL frame_rgb: got %0d bad shifts expected 0", rgb_bad); end
        n_checks++; if (ones_px !== 1) begin n_errors++; $display("FAIL pixel_r5c7: got %0d lit expected 1", ones_px); end
        n_checks++; if (ones_total !== 1) begin n_errors++; $display("FAIL pixel_total: got %0d lit expected 1", ones_total); end
        n_checks++; if (shift_bad !== 0) begin n_errors++; $display("FAIL frame_shifts: got %0d bad row-planes expected 0", shift_bad); end
        n_checks++; if (lat_bad !== 0) begin n_errors++; $display("FAIL frame_lat: got %0d bad row-planes expected 0", lat_bad); end
        n_checks++; if (oe_bad !== 0) begin n_errors++; $display("FAIL frame_display_len: got %0d bad row-planes expected 0", oe_bad); end
        n_checks++; if (addr_bad !== 0) begin n_errors++; $display("FAIL frame_row_addr: got %0d bad row-planes expected 0", addr_bad); end
        n_checks++; if (fd_bad !== 0 || fd_total !== 1) begin n_errors++; $display("FAIL frame_done: got %0d pulses, %0d misplaced expected 1, 0", fd_total, fd_bad); end
        capture(r, p, -1, sh, re, on, la, ol, fd, ad, rc, vi, to);
        n_checks++; if (ad !== 4'd0 || fd !== 0) begin n_errors++; $display("FAIL frame_wrap: got row %h fd %0d expected row 0 fd 0", ad, fd); end
    endtask

    task automatic test_en_drop;
        int sh, re, on, la, ol, fd, rc, vi, busy;
        logic [3:0] ad, r2;
        int p2;
        bit to;
        fill(1);
        do_reset(1'b1);
        capture(4'd0, FIRST_P, 10, sh, re, on, la, ol, fd, ad, rc, vi, to);
        n_checks++; if (sh !== 32 || la !== 1 || to !== 1'b0) begin n_errors++; $display("FAIL drop_complete: got %0d shifts %0d lat expected 32 1", sh, la); end
        n_checks++; if (ol !== dlen(FIRST_P)) begin n_errors++; $display("FAIL drop_display: got %0d expected %0d", ol, dlen(FIRST_P)); end
        busy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (fb_rd || clk_shft || LAT || !OE) busy++;
        end
        n_checks++; if (busy !== 0) begin n_errors++; $display("FAIL drop_idle: got %0d active cycles expected 0", busy); end
        if (FIRST_P == LAST_P) begin r2 = 4'd1; p2 = FIRST_P; end else begin r2 = 4'd0; p2 = FIRST_P + 1; end
        en = 1'b1;
        capture(r2, p2, -1, sh, re, on, la, ol, fd, ad, rc, vi, to);
        n_checks++; if (ad !== r2 || ol !== dlen(p2) || sh !== 32) begin n_errors++; $display("FAIL drop_resume: got row %h oe %0d shifts %0d expected row %h oe %0d shifts 32", ad, ol, sh, r2, dlen(p2)); end
    endtask

    task automatic test_reset_mid_display;
        int sh, re, on, la, ol, fd, rc, vi;
        logic [3:0] ad;
        bit found;
        fill(1);
        do_reset(1'b1);
        for (int k = 0; k < 2 * NPL; k++) capture(4'd0, FIRST_P, -1, sh, re, on, la, ol, fd, ad, rc, vi, found);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (!OE) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL mid_display_reached: got %b expected 1", found); end
        tick();
        n_checks++; if ({D, C, B, A} !== 4'd2 || OE !== 1'b0) begin n_errors++; $display("FAIL mid_pre_reset: got row %h oe %b expected row 2 oe 0", {D, C, B, A}, OE); end
        rst = 1'b1;
        tick();
        n_checks++; if (OE !== 1'b1) begin n_errors++; $display("FAIL mid_reset_oe: got %b expected 1", OE); end
        n_checks++; if ({D, C, B, A} !== 4'd0) begin n_errors++; $display("FAIL mid_reset_row_addr: got %h expected 0", {D, C, B, A}); end
        n_checks++; if ({R0, G0, B0, R1, G1, B1, LAT, clk_shft, fb_rd, frame_done} !== 10'd0) begin n_errors++; $display("FAIL mid_reset_outputs: got %b expected 0", {R0, G0, B0, R1, G1, B1, LAT, clk_shft, fb_rd, frame_done}); end
        n_checks++; if (fb_addr !== 9'd0) begin n_errors++; $display("FAIL mid_reset_fb_addr: got %h expected 0", fb_addr); end
        rst = 1'b0;
        capture(4'd0, FIRST_P, -1, sh, re, on, la, ol, fd, ad, rc, vi, found);
        n_checks++; if (ad !== 4'd0 || ol !== dlen(FIRST_P) || sh !== 32) begin n_errors++; $display("FAIL mid_restart: got row %h oe %0d shifts %0d expected row 0 oe %0d shifts 32", ad, ol, sh, dlen(FIRST_P)); end
    endtask

    initial begin
        test_reset();
        test_all_white();
        test_pattern();
        test_full_frame();
        test_en_drop();
        test_reset_mid_display();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hub75_scan_ctrl.md
HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

Interface
REQ-001 Parameter COLS, default 32, number of column shifts per row.
REQ-002 Parameter BASE_ON, default 8, OE-active clock cycles for the least-significant bit plane.
REQ-003 clk  input  1  the block's single clock; all logic SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  scan enable.
REQ-006 fb_rd  output  1  framebuffer read strobe.
REQ-007 fb_addr  output  9  framebuffer read address, formed as {row[3:0], col[4:0]}.
REQ-008 fb_rdata_top  input  12  pixel at row r, as {R[3:0],G[3:0],B[3:0]}; valid one cycle after fb_rd.
REQ-009 fb_rdata_bot  input  12  pixel at row r+16, same format and timing as fb_rdata_top.
REQ-010 A, B, C, D  output  1 each  panel row address; A is the LSB.
REQ-011 R0, G0, B0, R1, G1, B1  output  1 each  serial colour data for the top and bottom half.
REQ-012 clk_shft  output  1  panel shift clock.
REQ-013 LAT  output  1  panel latch.
REQ-014 OE  output  1  panel output enable, active-low.
REQ-015 frame_done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, SETUP, CLOCK, BLANK, LATCH, DISPLAY and NEXT.
REQ-017 In IDLE, the block SHALL hold OE=1 and SHALL enter FETCH when en=1, with col=0, the current row, and the current plane.
REQ-018 FETCH SHALL last 1 cycle, with fb_rd=1 and fb_addr={row,col}.
REQ-019 SETUP SHALL last 1 cycle: clk_shft=0; R0/G0/B0 SHALL be loaded from bit[plane] of the top R/G/B nibbles, and R1/G1/B1 from bit[plane] of the bottom nibbles.
REQ-020 CLOCK SHALL last 1 cycle with clk_shft=1 and RGB held; the block SHALL then go to FETCH with col+1 if col<COLS-1, else to BLANK.
REQ-021 Each row-plane SHALL therefore take exactly 3*COLS shift cycles; OE SHALL be 1 throughout FETCH, SETUP and CLOCK.
REQ-022 BLANK SHALL last 1 cycle with OE=1 and {D,C,B,A} updated to the current row.
REQ-023 LATCH SHALL last 1 cycle with LAT=1; LAT SHALL be 0 in every other state.
REQ-024 DISPLAY SHALL hold OE=0 for exactly BASE_ON<<plane cycles, then enter NEXT with OE=1.
REQ-025 NEXT SHALL increment plane and, when plane wraps past the last plane, increment row.
REQ-026 When row wraps from 15 to 0, frame_done SHALL pulse for exactly 1 cycle in NEXT.
REQ-027 NEXT SHALL go to FETCH if en=1, else to IDLE.
REQ-028 en SHALL be sampled only in IDLE and NEXT; deasserting en mid-row SHALL complete the current row-plane including its DISPLAY.
REQ-029 Row and plane counters SHALL persist across IDLE, so that scanning resumes where it stopped.
REQ-030 clk_shft SHALL never be 1 outside CLOCK, and OE SHALL never be 0 outside DISPLAY.

Reset
REQ-031 While rst=1, at any state including mid-operation, the next edge SHALL force state=IDLE, row=0, plane=0 and col=0.
REQ-032 On that same edge, the outputs SHALL be forced to OE=1, LAT=0, clk_shft=0, RGB outputs=0, A..D=0, fb_rd=0, fb_addr=0 and frame_done=0.
REQ-033 A DISPLAY interval interrupted by reset SHALL be abandoned, not completed.

Configuration
REQ-034 The macro SCAN_BCM_EN SHALL select the colour depth.
REQ-035 With SCAN_BCM_EN defined, 4 bit planes (0..3) SHALL be used, with DISPLAY lengths of BASE_ON, 2*, 4* and 8* BASE_ON, giving 4-bit colour per channel.
REQ-036 Without SCAN_BCM_EN, only plane 3 (MSB) SHALL be used: the plane SHALL be fixed at 3, DISPLAY length SHALL be BASE_ON cycles, and row SHALL advance on every NEXT.

Verification
REQ-037 Reset then en=1 with all pixels 12'hFFF -> 32 clk_shft pulses, each with RGB=1; then 1 LAT pulse; then OE=0 for 8 cycles (plane 0, BCM).
REQ-038 Pixel (row 5, col 7) top=12'h800, others 0, BCM build -> on row 5, plane 3, column 7, R0=1 at the clk_shft rise, with G0=B0=R1=0; R0=0 on planes 0..2.
REQ-039 Full frame, BCM build -> frame_done pulses once per 16*4 row-planes, and {D,C,B,A} steps 0..15 then back to 0.
REQ-040 en dropped during column 10 -> the row-plane completes (32 shifts, LAT, DISPLAY), then IDLE with OE=1; reasserting en resumes at the next row-plane.
REQ-041 rst asserted during DISPLAY -> the next cycle shows OE=1, A..D=0, and state IDLE; scanning restarts at row 0, plane 0.
REQ-042 Non-BCM build -> every DISPLAY is 8 cycles, only bit 3 of each nibble is shifted, and frame_done occurs every 16 rows.
